// File: rtl/bridge_pkg.sv
// Shared types and constants for the ASCII request parser feeding the analyzer bus.
package bridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic [7:0] CHAR_R    = 8'h52;
    localparam logic [7:0] CHAR_W    = 8'h57;
    localparam logic [7:0] CHAR_LC_R = 8'h72;
    localparam logic [7:0] CHAR_LC_W = 8'h77;
    localparam logic [7:0] CHAR_CR   = 8'h0D;
    localparam logic [7:0] CHAR_LF   = 8'h0A;

    localparam int BUS_ADDR_W = 16;
    localparam int BUS_DATA_W = 16;

    localparam logic [3:0] READ_NIBBLES  = 4'd4;
    localparam logic [3:0] WRITE_NIBBLES = 4'd8;

endpackage

// File: rtl/bridge_rx_hex_decode.sv
// Combinational ASCII hex digit decoder; lowercase digits optional.
module hex_decode #(
    parameter bit ACCEPT_LOWERCASE = 1'b1
) (
    input  logic [7:0] data,
    output logic       is_hex,
    output logic [3:0] nibble
);

    always_comb begin
        is_hex = 1'b0;
        nibble = 4'd0;
        if (data >= 8'h30 && data <= 8'h39) begin
            is_hex = 1'b1;
            nibble = data[3:0];
        end else if (data >= 8'h41 && data <= 8'h46) begin
            // 'A'..'F' have low nibbles 1..6, so adding 9 lands on 10..15
            is_hex = 1'b1;
            nibble = data[3:0] + 4'd9;
        end else if (ACCEPT_LOWERCASE && data >= 8'h61 && data <= 8'h66) begin
            is_hex = 1'b1;
            nibble = data[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/bridge_rx.sv
// Parses 'R'AAAA / 'W'AAAADDDD ASCII requests into single-cycle 16-bit bus strobes.
module bridge_rx
    import bridge_pkg::*;
#(
    parameter bit ACCEPT_LOWERCASE = 1'b1,
    parameter int TIMEOUT_CYCLES   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            data_i,
    input  logic                  valid_i,
    output logic [BUS_ADDR_W-1:0] addr_o,
    output logic [BUS_DATA_W-1:0] wdata_o,
    output logic [BUS_DATA_W-1:0] rdata_o,
    output logic                  rw_o,
    output logic                  valid_o
);

    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_t        state, state_n, eff_state;
    logic [31:0]   shift_buf;
    logic [3:0]    nib_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_fire;
    logic          is_hex;
    logic [3:0]    nibble;
    logic          is_term, is_start_r, is_start_w;
    logic [3:0]    max_cnt;
    logic          shift_en, cnt_clr, emit;

    hex_decode #(.ACCEPT_LOWERCASE(ACCEPT_LOWERCASE)) u_hex (
        .data   (data_i),
        .is_hex (is_hex),
        .nibble (nibble)
    );

    assign is_term    = (data_i == CHAR_CR) || (data_i == CHAR_LF);
    assign is_start_r = (data_i == CHAR_R) || (ACCEPT_LOWERCASE && data_i == CHAR_LC_R);
    assign is_start_w = (data_i == CHAR_W) || (ACCEPT_LOWERCASE && data_i == CHAR_LC_W);
    assign max_cnt    = (state == WRITE) ? WRITE_NIBBLES : READ_NIBBLES;
    assign tmo_fire   = (TIMEOUT_CYCLES != 0) && (state != IDLE) && (tmo_cnt == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        shift_en = 1'b0;
        cnt_clr  = 1'b0;
        emit     = 1'b0;
        // a byte landing on the timeout cycle is handled as if already idle
        eff_state = tmo_fire ? IDLE : state;
        if (tmo_fire) begin
            state_n = IDLE;
            cnt_clr = 1'b1;
        end
        case (eff_state)
            IDLE: begin
                if (valid_i) begin
                    if (is_start_r) begin
                        state_n = READ;
                        cnt_clr = 1'b1;
                    end else if (is_start_w) begin
                        state_n = WRITE;
                        cnt_clr = 1'b1;
                    end
                end
            end
            READ, WRITE: begin
                if (valid_i) begin
                    if (is_hex) begin
                        if (nib_cnt == max_cnt) state_n = IDLE;
                        else                    shift_en = 1'b1;
                    end else if (is_term) begin
                        emit    = (nib_cnt == max_cnt);
                        state_n = IDLE;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_buf <= 32'd0;
            nib_cnt   <= 4'd0;
        end else if (cnt_clr) begin
            shift_buf <= 32'd0;
            nib_cnt   <= 4'd0;
        end else if (shift_en) begin
            shift_buf <= {shift_buf[27:0], nibble};
            nib_cnt   <= nib_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == IDLE || valid_i || tmo_fire) begin
            tmo_cnt <= '0;
        end else if (TIMEOUT_CYCLES != 0) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_o  <= '0;
            wdata_o <= '0;
            rw_o    <= 1'b0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= emit;
            if (emit) begin
                rw_o <= (state == WRITE);
                if (state == WRITE) begin
                    addr_o  <= shift_buf[31:16];
                    wdata_o <= shift_buf[15:0];
                end else begin
                    addr_o  <= shift_buf[15:0];
                    wdata_o <= '0;
                end
            end
        end
    end

    assign rdata_o = '0;

endmodule

// File: tb/tb_bridge_rx.sv
// Directed bench for bridge_rx: lowercase/timeout instance plus uppercase-only instance.
module tb_bridge_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  data = 8'h00;
    logic        valid = 1'b0;

    logic [15:0] addr_a, wdata_a, rdata_a, addr_b, wdata_b, rdata_b;
    logic        rw_a, valid_a, rw_b, valid_b;

    int checks   = 0;
    int failures = 0;
    int n_a = 0, n_b = 0, pulse_err = 0;
    int base_a, base_b;
    logic prev_a = 1'b0;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    always #5 clk = ~clk;

    bridge_rx #(.ACCEPT_LOWERCASE(1'b1), .TIMEOUT_CYCLES(20)) dut_a (
        .clk(clk), .rst(rst), .data_i(data), .valid_i(valid),
        .addr_o(addr_a), .wdata_o(wdata_a), .rdata_o(rdata_a), .rw_o(rw_a), .valid_o(valid_a)
    );

    bridge_rx #(.ACCEPT_LOWERCASE(1'b0), .TIMEOUT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .data_i(data), .valid_i(valid),
        .addr_o(addr_b), .wdata_o(wdata_b), .rdata_o(rdata_b), .rw_o(rw_b), .valid_o(valid_b)
    );

    always @(negedge clk) begin
        if (valid_a) begin
            n_a = n_a + 1;
            if (prev_a) pulse_err = pulse_err + 1;
        end
        if (valid_b) n_b = n_b + 1;
        prev_a = valid_a;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        @(negedge clk);
        data  = b;
        valid = 1'b1;
    endtask

    task automatic put_str(input string s);
        for (int i = 0; i < s.len(); i++) put(s[i]);
    endtask

    task automatic idle();
        @(negedge clk);
        valid = 1'b0;
        data  = 8'h00;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic mark();
        base_a = n_a;
        base_b = n_b;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("rst_addr",  {16'd0, addr_a},  32'h0);
        check("rst_wdata", {16'd0, wdata_a}, 32'h0);
        check("rst_rw",    {31'd0, rw_a},    32'h0);
        check("rst_valid", {31'd0, valid_a}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // 1: read with CRLF terminator
        mark();
        put_str("R0012"); put(CR); put(LF); idle(); settle();
        check("t1_count", n_a - base_a, 1);
        check("t1_addr",  {16'd0, addr_a},  32'h0012);
        check("t1_rw",    {31'd0, rw_a},    32'h0);
        check("t1_wdata", {16'd0, wdata_a}, 32'h0);

        // 2: write, strobe exactly the cycle after CR
        mark();
        put_str("W000A1234"); put(CR); idle();
        check("t2_strobe_now",  {31'd0, valid_a}, 32'h1);
        @(negedge clk);
        check("t2_strobe_gone", {31'd0, valid_a}, 32'h0);
        settle();
        check("t2_count", n_a - base_a, 1);
        check("t2_addr",  {16'd0, addr_a},  32'h000A);
        check("t2_wdata", {16'd0, wdata_a}, 32'h1234);
        check("t2_rw",    {31'd0, rw_a},    32'h1);

        // 3: malformed messages then a good read
        mark();
        put_str("R12G4"); put(CR);
        put_str("R123");  put(CR);
        put_str("R12345"); put(CR); idle(); settle();
        check("t3_bad_count", n_a - base_a, 0);
        check("t3_hold_addr", {16'd0, addr_a}, 32'h000A);
        put_str("R0001"); put(LF); idle(); settle();
        check("t3_count", n_a - base_a, 1);
        check("t3_addr",  {16'd0, addr_a},  32'h0001);
        check("t3_wdata", {16'd0, wdata_a}, 32'h0);

        // 4: lowercase accepted only by dut_a
        mark();
        put_str("w00ffbeef"); put(LF); idle(); settle();
        check("t4_lc_count", n_a - base_a, 1);
        check("t4_lc_addr",  {16'd0, addr_a},  32'h00FF);
        check("t4_lc_wdata", {16'd0, wdata_a}, 32'hBEEF);
        check("t4_lc_rw",    {31'd0, rw_a},    32'h1);
        check("t4_uc_count", n_b - base_b, 0);

        // 5: timeout drops a stalled message; a shorter gap does not
        mark();
        put_str("W00"); idle();
        repeat (25) @(negedge clk);
        put_str("012340"); put(CR); idle(); settle();
        check("t5_timeout_count", n_a - base_a, 0);
        put_str("W00"); idle();
        repeat (10) @(negedge clk);
        put_str("012340"); put(CR); idle(); settle();
        check("t5_gap_count", n_a - base_a, 1);
        check("t5_addr",  {16'd0, addr_a},  32'h0001);
        check("t5_wdata", {16'd0, wdata_a}, 32'h2340);

        // 6: reset mid-message
        mark();
        put_str("W0003AB"); idle();
        #2 rst = 1'b1;
        #1;
        check("t6_rst_addr",  {16'd0, addr_a},  32'h0);
        check("t6_rst_wdata", {16'd0, wdata_a}, 32'h0);
        check("t6_rst_rw",    {31'd0, rw_a},    32'h0);
        @(negedge clk);
        rst = 1'b0;
        put_str("CD"); put(CR); idle(); settle();
        check("t6_no_strobe", n_a - base_a, 0);
        check("t6_addr_zero", {16'd0, addr_a},  32'h0);
        check("t6_wdata_zero",{16'd0, wdata_a}, 32'h0);
        put_str("R0003"); put(CR); idle(); settle();
        check("t6_count", n_a - base_a, 1);
        check("t6_addr",  {16'd0, addr_a}, 32'h0003);
        check("t6_rw",    {31'd0, rw_a},   32'h0);

        check("rdata_zero",  {16'd0, rdata_a}, 32'h0);
        check("pulse_width", pulse_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
